perf_counter_bank: RTL and testbench
====================================

Name: perf_counter_bank

Overview:
- Multi-channel successor to the single stall/event performance counter in the LC-3b MP3 pipeline.
- Each of NUM_CH channels watches one event line (cache miss-busy, branch mispredict, stage stall, ...).
- Each channel counts occurrences where the event stays high for at least a programmable threshold of consecutive cycles.
- Per-channel threshold and mode are configured through a write port; counts, overflow flags and activity are read through a registered read port for debug/MMIO.

Parameters:
- NUM_CH, 4, number of independent channels (1..16).
- CNT_WIDTH, 16, width of each event count (lc3b_word by default).
- RUN_WIDTH, 4, width of the consecutive-cycle run counter and of the threshold.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high; clears all state and config.
- event_i  in  NUM_CH  per-channel event level; bit n drives channel n.
- freeze_i  in  1  global hold; count increments are suppressed while high.
- clear_i  in  NUM_CH  per-channel clear of count, run counter and overflow flag; config is kept.
- cfg_we  in  1  config write strobe.
- cfg_sel  in  $clog2(NUM_CH) (min 1)  channel targeted by the write.
- cfg_thresh  in  RUN_WIDTH  threshold to store.
- cfg_mode  in  1  0 = ONESHOT (one count per run), 1 = CONT (one count per cycle at or above threshold).
- rd_sel  in  $clog2(NUM_CH) (min 1)  channel to read.
- rd_count  out  CNT_WIDTH  registered count of channel rd_sel.
- rd_ovf  out  1  registered sticky overflow flag of channel rd_sel.
- ovf_any  out  1  OR of all channel overflow flags (registered).
- active  out  NUM_CH  per-channel "count incremented this cycle" pulse (registered).

Behaviour:
- Reset values: all counts, run counters, armed flags and overflow flags are 0; thresh = 0 and mode = ONESHOT for every channel. Outputs rd_count = 0, rd_ovf = 0, ovf_any = 0, active = 0.
- Per-channel state: run (RUN_WIDTH), fired (1), count (CNT_WIDTH), ovf (1), thresh, mode.
- Run tracking, evaluated every cycle independent of freeze:
  - event low: run <= 0, fired <= 0.
  - event high and run != thresh: run <= run + 1.
  - event high and run == thresh: run holds.
- Hit: a cycle where event is high and run == thresh. With thresh = 0, the first high cycle is a hit.
- Increment condition: hit AND (mode == CONT OR !fired) AND !freeze_i. On increment, fired <= 1.
- ONESHOT therefore counts once per run; the run must drop low to re-arm. A hit suppressed by freeze does not set fired.
- Saturation: if count == all-ones, the count holds and ovf <= 1; ovf is sticky until clear_i or reset.
- Priority per channel: reset > clear_i[n] > increment. A clear in the same cycle as a hit zeroes count, run and fired; the hit is lost.
- Config write: when cfg_we = 1, thresh/mode of channel cfg_sel update at the clock edge. The new values are used from the next cycle. run and fired are not reset, so a lowered threshold is met once run reaches the new value.
- cfg_sel or rd_sel >= NUM_CH: a write is ignored; a read returns count 0 and ovf 0.
- Read latency: 1 cycle. rd_count/rd_ovf reflect the post-update state of the channel selected in the previous cycle. Same-cycle increment and read returns the pre-increment value.
- active[n] = 1 exactly one cycle after each increment of channel n. ovf_any is registered, 1 cycle after any ovf sets.

Decomposition:
- Package perf_types (beside lc3b_types): perf_mode_t enum {PERF_ONESHOT, PERF_CONT}, PERF_MAX_CH constant.
- Sub-module perf_channel holds one channel's run/fired/count/ovf/config and its increment logic. The bank generates NUM_CH instances plus the config decode and read mux.

Test Plan:
- Reset, thresh = 2, ONESHOT on ch0; event_i[0] high 6 cycles, low 1, high 3 -> count 2; active[0] pulses twice.
- ch1 CONT, thresh = 2; event high 6 cycles -> hits on cycles 3..6 -> count 4.
- thresh = 0 ONESHOT, three 1-cycle pulses separated by low cycles -> count 3.
- CNT_WIDTH = 4, CONT thresh = 0, event held 20 cycles -> count saturates at 15; rd_ovf = 1; ovf_any = 1; then clear_i -> count 0, ovf 0 next read.
- freeze_i high during a 5-cycle ONESHOT run (thresh 1), released mid-run -> counted once after release; with freeze high for the whole run -> count 0.
- Same-cycle clear_i[2] and hit on ch2 -> count 0; cfg write with cfg_sel = NUM_CH -> no channel config changes; rd_sel out of range -> rd_count = 0.

Source files
------------

// File: rtl/perf_counter_bank_pkg.sv
// Shared types and limits for the performance-counter bank.
// This file holds the mode enum, the channel limit and the select-width helper.
package perf_types;

  typedef enum logic {
    PERF_ONESHOT = 1'b0,
    PERF_CONT    = 1'b1
  } perf_mode_t;

  localparam int PERF_MAX_CH = 16;

  // Select width for a channel count. It never drops below 1 bit, so NUM_CH = 1 still has a port.
  function automatic int perf_sel_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/perf_counter_bank_if.sv
// Config-write and debug-read bus of the performance-counter bank.
// The master drives config and read select. The slave returns the registered read data.
interface perf_counter_bank_if
  import perf_types::*;
#(
  parameter int NUM_CH    = 4,
  parameter int CNT_WIDTH = 16,
  parameter int RUN_WIDTH = 4
) ();
  localparam int SEL_W = perf_sel_width(NUM_CH);

  logic                 cfg_we;
  logic [SEL_W-1:0]     cfg_sel;
  logic [RUN_WIDTH-1:0] cfg_thresh;
  perf_mode_t           cfg_mode;
  logic [SEL_W-1:0]     rd_sel;
  logic [CNT_WIDTH-1:0] rd_count;
  logic                 rd_ovf;

  modport master (
    output cfg_we, cfg_sel, cfg_thresh, cfg_mode, rd_sel,
    input  rd_count, rd_ovf
  );

  modport slave (
    input  cfg_we, cfg_sel, cfg_thresh, cfg_mode, rd_sel,
    output rd_count, rd_ovf
  );
endinterface

// File: rtl/perf_counter_bank_channel.sv
// One performance-counter channel: run tracking, threshold hit, saturating count and sticky overflow.
module perf_channel
  import perf_types::*;
#(
  parameter int CNT_WIDTH = 16,
  parameter int RUN_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 event_i,
  input  logic                 freeze_i,
  input  logic                 clear_i,
  input  logic                 cfg_we,
  input  logic [RUN_WIDTH-1:0] cfg_thresh,
  input  perf_mode_t           cfg_mode,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 ovf,
  output logic                 inc
);
  logic [RUN_WIDTH-1:0] run_r;
  logic                 fired_r;
  logic [CNT_WIDTH-1:0] count_r;
  logic                 ovf_r;
  logic [RUN_WIDTH-1:0] thresh_r;
  perf_mode_t           mode_r;

  logic hit_s;
  logic inc_s;
  logic sat_s;

  // Hit and increment qualification. A frozen hit is not an increment, so it never arms fired.
  always_comb begin
    hit_s = event_i && (run_r == thresh_r);
    inc_s = hit_s && ((mode_r == PERF_CONT) || !fired_r) && !freeze_i;
    sat_s = &count_r;
  end

  // Channel state and config registers; clear outranks increment but keeps config
  always_ff @(posedge clk) begin
    if (reset) begin
      run_r    <= {RUN_WIDTH{1'b0}};
      fired_r  <= 1'b0;
      count_r  <= {CNT_WIDTH{1'b0}};
      ovf_r    <= 1'b0;
      thresh_r <= {RUN_WIDTH{1'b0}};
      mode_r   <= PERF_ONESHOT;
    end else begin
      if (cfg_we) begin
        thresh_r <= cfg_thresh;
        mode_r   <= cfg_mode;
      end
      if (clear_i) begin
        run_r   <= {RUN_WIDTH{1'b0}};
        fired_r <= 1'b0;
        count_r <= {CNT_WIDTH{1'b0}};
        ovf_r   <= 1'b0;
      end else begin
        if (!event_i) begin
          run_r   <= {RUN_WIDTH{1'b0}};
          fired_r <= 1'b0;
        end else if (run_r != thresh_r) begin
          run_r <= run_r + {{(RUN_WIDTH-1){1'b0}}, 1'b1};
        end
        if (inc_s) begin
          fired_r <= 1'b1;
          if (sat_s) begin
            ovf_r <= 1'b1;
          end else begin
            count_r <= count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
          end
        end
      end
    end
  end

  assign count = count_r;
  assign ovf   = ovf_r;
  // Reported only when the count really advances (not saturated, not cleared)
  assign inc   = inc_s && !sat_s && !clear_i;
endmodule

// File: rtl/perf_counter_bank.sv
// Bank of NUM_CH thresholded event counters with a config decode and a registered debug read port.
module perf_counter_bank
  import perf_types::*;
#(
  parameter int NUM_CH    = 4,
  parameter int CNT_WIDTH = 16,
  parameter int RUN_WIDTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_CH-1:0]   event_i,
  input  logic                freeze_i,
  input  logic [NUM_CH-1:0]   clear_i,
  perf_counter_bank_if.slave  bus,
  output logic                ovf_any,
  output logic [NUM_CH-1:0]   active
);
  localparam int SEL_W = perf_sel_width(NUM_CH);

  logic [NUM_CH-1:0]    cfg_hit_s;
  logic [NUM_CH-1:0]    inc_s;
  logic [NUM_CH-1:0]    ovf_s;
  logic [CNT_WIDTH-1:0] count_s [NUM_CH];

  logic [CNT_WIDTH-1:0] rd_count_s;
  logic                 rd_ovf_s;
  logic [CNT_WIDTH-1:0] rd_count_r;
  logic                 rd_ovf_r;
  logic                 ovf_any_r;
  logic [NUM_CH-1:0]    active_r;

  // An out-of-range cfg_sel matches no channel, so the write is dropped
  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    assign cfg_hit_s[ch] = bus.cfg_we && (bus.cfg_sel == SEL_W'(ch));

    perf_channel #(
      .CNT_WIDTH (CNT_WIDTH),
      .RUN_WIDTH (RUN_WIDTH)
    ) u_channel (
      .clk        (clk),
      .reset      (reset),
      .event_i    (event_i[ch]),
      .freeze_i   (freeze_i),
      .clear_i    (clear_i[ch]),
      .cfg_we     (cfg_hit_s[ch]),
      .cfg_thresh (bus.cfg_thresh),
      .cfg_mode   (bus.cfg_mode),
      .count      (count_s[ch]),
      .ovf        (ovf_s[ch]),
      .inc        (inc_s[ch])
    );
  end

  // Read mux; out-of-range selects read as zero
  always_comb begin
    rd_count_s = {CNT_WIDTH{1'b0}};
    rd_ovf_s   = 1'b0;
    if (int'(bus.rd_sel) < NUM_CH) begin
      rd_count_s = count_s[bus.rd_sel];
      rd_ovf_s   = ovf_s[bus.rd_sel];
    end else begin
      rd_count_s = {CNT_WIDTH{1'b0}};
      rd_ovf_s   = 1'b0;
    end
  end

  // Output registers: read data, overflow summary and per-channel activity pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_count_r <= {CNT_WIDTH{1'b0}};
      rd_ovf_r   <= 1'b0;
      ovf_any_r  <= 1'b0;
      active_r   <= {NUM_CH{1'b0}};
    end else begin
      rd_count_r <= rd_count_s;
      rd_ovf_r   <= rd_ovf_s;
      ovf_any_r  <= |ovf_s;
      active_r   <= inc_s;
    end
  end

  assign bus.rd_count = rd_count_r;
  assign bus.rd_ovf   = rd_ovf_r;
  assign ovf_any      = ovf_any_r;
  assign active       = active_r;
endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed self-checking bench for perf_counter_bank: a 4-channel 16-bit bank plus a 3-channel 4-bit bank.
module tb_perf_counter_bank;
  import perf_types::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       frz;
  logic [3:0] ev_a, clr_a, active_a;
  logic       ovf_any_a;
  logic [2:0] ev_b, clr_b, active_b;
  logic       ovf_any_b;

  int checks = 0;
  int errors = 0;
  int act0_cnt = 0;
  logic [31:0] rc;
  logic        ro;

  perf_counter_bank_if #(.NUM_CH(4), .CNT_WIDTH(16), .RUN_WIDTH(4)) bus_a ();
  perf_counter_bank_if #(.NUM_CH(3), .CNT_WIDTH(4),  .RUN_WIDTH(4)) bus_b ();

  perf_counter_bank #(.NUM_CH(4), .CNT_WIDTH(16), .RUN_WIDTH(4)) dut_a (
    .clk(clk), .reset(reset), .event_i(ev_a), .freeze_i(frz), .clear_i(clr_a),
    .bus(bus_a), .ovf_any(ovf_any_a), .active(active_a));

  perf_counter_bank #(.NUM_CH(3), .CNT_WIDTH(4), .RUN_WIDTH(4)) dut_b (
    .clk(clk), .reset(reset), .event_i(ev_b), .freeze_i(frz), .clear_i(clr_b),
    .bus(bus_b), .ovf_any(ovf_any_b), .active(active_b));

  task automatic step();
    @(posedge clk);
    #1;
    act0_cnt += int'(active_a[0]);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cfg_a(input logic [1:0] sel, input logic [3:0] th, input perf_mode_t m);
    bus_a.cfg_we = 1'b1; bus_a.cfg_sel = sel; bus_a.cfg_thresh = th; bus_a.cfg_mode = m;
    step();
    bus_a.cfg_we = 1'b0;
  endtask

  task automatic cfg_b(input logic [1:0] sel, input logic [3:0] th, input perf_mode_t m);
    bus_b.cfg_we = 1'b1; bus_b.cfg_sel = sel; bus_b.cfg_thresh = th; bus_b.cfg_mode = m;
    step();
    bus_b.cfg_we = 1'b0;
  endtask

  task automatic rd_a(input logic [1:0] sel, output logic [31:0] c, output logic o);
    bus_a.rd_sel = sel;
    step();
    c = 32'(bus_a.rd_count);
    o = bus_a.rd_ovf;
  endtask

  task automatic rd_b(input logic [1:0] sel, output logic [31:0] c, output logic o);
    bus_b.rd_sel = sel;
    step();
    c = 32'(bus_b.rd_count);
    o = bus_b.rd_ovf;
  endtask

  initial begin
    reset = 1'b1; frz = 1'b0;
    ev_a = 4'd0; clr_a = 4'd0; ev_b = 3'd0; clr_b = 3'd0;
    bus_a.cfg_we = 1'b0; bus_a.cfg_sel = 2'd0; bus_a.cfg_thresh = 4'd0;
    bus_a.cfg_mode = PERF_ONESHOT; bus_a.rd_sel = 2'd0;
    bus_b.cfg_we = 1'b0; bus_b.cfg_sel = 2'd0; bus_b.cfg_thresh = 4'd0;
    bus_b.cfg_mode = PERF_ONESHOT; bus_b.rd_sel = 2'd0;
    step(); step();
    reset = 1'b0;

    chk("reset_rd_count", 32'(bus_a.rd_count), 32'd0);
    chk("reset_rd_ovf", 32'(bus_a.rd_ovf), 32'd0);
    chk("reset_ovf_any", 32'(ovf_any_a), 32'd0);
    chk("reset_active", 32'(active_a), 32'd0);
    chk("reset_ovf_any_b", 32'(ovf_any_b), 32'd0);

    // ch0 ONESHOT thresh 2: 6 high, 1 low, 3 high -> two counts
    cfg_a(2'd0, 4'd2, PERF_ONESHOT);
    act0_cnt = 0;
    ev_a[0] = 1'b1; repeat (6) step();
    ev_a[0] = 1'b0; step();
    ev_a[0] = 1'b1; repeat (3) step();
    ev_a[0] = 1'b0; step(); step();
    chk("oneshot_active_pulses", 32'(act0_cnt), 32'd2);
    rd_a(2'd0, rc, ro);
    chk("oneshot_count", rc, 32'd2);

    // ch1 CONT thresh 2, 6 high cycles -> hits on cycles 3..6
    cfg_a(2'd1, 4'd2, PERF_CONT);
    ev_a[1] = 1'b1; repeat (6) step();
    ev_a[1] = 1'b0; step();
    rd_a(2'd1, rc, ro);
    chk("cont_count", rc, 32'd4);

    // ch3 default config (thresh 0, ONESHOT): three single-cycle pulses
    repeat (3) begin
      ev_a[3] = 1'b1; step();
      ev_a[3] = 1'b0; step();
    end
    rd_a(2'd3, rc, ro);
    chk("thresh0_pulses", rc, 32'd3);

    // ch2 ONESHOT thresh 1: freeze released mid-run -> one count
    cfg_a(2'd2, 4'd1, PERF_ONESHOT);
    ev_a[2] = 1'b1; frz = 1'b1;
    repeat (3) step();
    frz = 1'b0;
    repeat (2) step();
    ev_a[2] = 1'b0; step();
    rd_a(2'd2, rc, ro);
    chk("freeze_release", rc, 32'd1);

    // freeze across the whole run -> no further count
    frz = 1'b1; ev_a[2] = 1'b1;
    repeat (5) step();
    ev_a[2] = 1'b0; step();
    frz = 1'b0;
    rd_a(2'd2, rc, ro);
    chk("freeze_whole_run", rc, 32'd1);

    // clear and hit in the same cycle on ch2 -> count 0, no activity pulse
    ev_a[2] = 1'b1; step();
    clr_a[2] = 1'b1; step();
    chk("clear_hit_active", 32'(active_a[2]), 32'd0);
    clr_a[2] = 1'b0; ev_a[2] = 1'b0; step();
    rd_a(2'd2, rc, ro);
    chk("clear_hit_count", rc, 32'd0);

    // bank B: a write to cfg_sel = NUM_CH must leave every channel at thresh 0 ONESHOT
    cfg_b(2'd3, 4'd5, PERF_CONT);
    ev_b = 3'b111; repeat (3) step();
    ev_b = 3'b000; step();
    rd_b(2'd0, rc, ro); chk("oor_cfg_ch0", rc, 32'd1);
    rd_b(2'd1, rc, ro); chk("oor_cfg_ch1", rc, 32'd1);
    rd_b(2'd2, rc, ro); chk("oor_cfg_ch2", rc, 32'd1);
    rd_b(2'd3, rc, ro);
    chk("oor_rd_count", rc, 32'd0);
    chk("oor_rd_ovf", 32'(ro), 32'd0);

    // 4-bit CONT thresh 0 held 20 cycles -> saturate at 15 and flag overflow
    cfg_b(2'd0, 4'd0, PERF_CONT);
    ev_b[0] = 1'b1; repeat (20) step();
    ev_b[0] = 1'b0; step();
    chk("sat_ovf_any", 32'(ovf_any_b), 32'd1);
    rd_b(2'd0, rc, ro);
    chk("sat_count", rc, 32'd15);
    chk("sat_rd_ovf", 32'(ro), 32'd1);
    clr_b[0] = 1'b1; step();
    clr_b[0] = 1'b0;
    rd_b(2'd0, rc, ro);
    chk("clear_count", rc, 32'd0);
    chk("clear_rd_ovf", 32'(ro), 32'd0);
    chk("clear_ovf_any", 32'(ovf_any_b), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
